output_serializer: RTL and testbench
====================================

// Module: output_serializer
// PURPOSE
// Next-generation result drain for the systolic array. A start request arms a programmable
// delay, then the block snapshots the full ROWSxCOLS result bus into a shadow register.
// It streams the snapshot out row-major over LANES serial lanes, using a valid/ready handshake.
// The array may be recomputing while an earlier frame drains; backpressure stalls the stream.
// PARAMETERS
// D_W        8  operand width; each result element is 2*D_W bits
// ROWS       2  array rows
// COLS       2  array columns
// LANES      1  output lanes per beat; must divide 2*D_W, elaboration error otherwise
// INIT_DELAY 2  cycles from sampled init to snapshot capture (0..255)
// MSB_FIRST  0  0: least-significant lane chunk of each element first; 1: most-significant first
// PORTS
// clk        in   1                 clock, all logic on rising edge
// rst        in   1                 reset, asynchronous, active-high
// core_out_z in   ROWS*COLS*2*D_W   element (r,c) at bits [(r*COLS+c)*2*D_W +: 2*D_W]
// init       in   1                 start request, sampled each cycle
// err_clr    in   1                 clears overrun
// data_out   out  LANES             current beat payload
// tx_valid   out  1                 beat valid
// tx_ready   in   1                 sink accepts beat when tx_valid&&tx_ready
// tx_first   out  1                 high with first beat of frame
// tx_last    out  1                 high with last beat of frame
// busy       out  1                 high in WAIT or SEND
// overrun    out  1                 sticky: init seen while busy
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, all counters 0, tx_valid=tx_first=tx_last=busy=overrun=0, data_out=0.
// - Shadow register is not reset.
// - BEATS_PER_EL = 2*D_W/LANES. Frame = ROWS*COLS*BEATS_PER_EL beats.
// - Frame order: elements (0,0),(0,1)..(ROWS-1,COLS-1); beats within each element ordered per MSB_FIRST.
// - Beat k of an element with MSB_FIRST=0 is elem[k*LANES +: LANES].
// - With MSB_FIRST=1, beat k is elem[(BEATS_PER_EL-1-k)*LANES +: LANES]; lane order within a beat is unchanged.
// - FSM states: IDLE, WAIT, SEND.
// - IDLE, init=1 at edge t:
//   - INIT_DELAY=0: capture at edge t and go to SEND.
//   - Otherwise go to WAIT with dcnt=INIT_DELAY-1.
// - WAIT: dcnt decrements each edge. When dcnt==0, capture at that edge (edge t+INIT_DELAY) and go to SEND.
// - SEND: tx_valid=1. data_out, tx_first and tx_last are decoded from the shadow register and counters.
//   - They are stable while tx_ready=0; a beat is never dropped or repeated.
// - Accepted beat: advance beat counter; it wraps at BEATS_PER_EL, then advance col.
//   - col wraps at COLS, then advance row.
// - Accepted beat with tx_last: go to IDLE and clear counters. tx_valid=0 next cycle.
// - First-beat latency with tx_ready held 1: tx_valid rises INIT_DELAY+1 cycles after the init edge.
//   Frame completes INIT_DELAY+frame cycles after the init edge.
// - init while busy (WAIT or SEND): ignored, the frame continues unaffected, overrun<=1.
// - overrun clears only on err_clr=1 in IDLE, or on rst. If init and err_clr are both high while busy, overrun is set.
// - init in the same cycle as the final accepted beat: ignored, overrun set. IDLE must see init again.
// - core_out_z changes after capture do not affect the current frame.
// - Outputs in IDLE: data_out=0, tx_valid=0, busy=0.
// - Counter widths use $clog2 with a minimum of 1 bit, so ROWS=1, COLS=1 or BEATS_PER_EL=1 is legal.
// TESTING
// - Defaults (ROWS=COLS=2, D_W=8, LANES=1), elements 0x0001,0x8000,0x00FF,0x1234, tx_ready=1, init pulse:
//   -> 64 beats LSB-first, bit0=1 then 15 zeros.
//   -> tx_first on beat 0, tx_last on beat 63, tx_valid rises 3 cycles after init.
// - LANES=4, MSB_FIRST=1, element (0,0)=0xA5C3 -> first beats data_out=0xA,0x5,0xC,0x3. 16 beats total.
// - Random tx_ready backpressure (~50%) -> received sequence identical to ready=1 run.
//   data_out stable whenever valid&&!ready.
// - Overwrite core_out_z with 0xFFFF everywhere one cycle after capture -> streamed frame still holds the original values.
// - Second init pulse mid-SEND -> frame unchanged, overrun=1 until err_clr in IDLE.
//   A fresh init afterwards starts a new frame.
// - Assert rst asynchronously mid-frame (between edges) -> tx_valid and busy drop immediately.
//   Next init yields a complete frame from beat 0.

Source files
------------

// File: rtl/output_serializer.sv
// Result drain: snapshots the ROWSxCOLS result bus after a programmable delay and
// streams it row-major over LANES serial lanes with a valid/ready handshake.
module output_serializer #(
    parameter int unsigned D_W        = 8,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned COLS       = 2,
    parameter int unsigned LANES      = 1,
    parameter int unsigned INIT_DELAY = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ROWS*COLS*2*D_W-1:0]   core_out_z,
    input  logic                         init,
    input  logic                         err_clr,
    output logic [LANES-1:0]             data_out,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_first,
    output logic                         tx_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned EL_W  = 2 * D_W;
    localparam int unsigned BEATS = (LANES == 0) ? 1 : EL_W / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CW    = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int unsigned RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;

    localparam logic [BW-1:0] BEAT_MAX = BW'(BEATS - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);

    if (LANES == 0 || (EL_W % LANES) != 0) begin : g_bad_lanes
        $error("output_serializer: LANES must divide 2*D_W");
    end
    if (INIT_DELAY > 255) begin : g_bad_delay
        $error("output_serializer: INIT_DELAY must be 0..255");
    end

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t          state_q, state_d;
    logic [7:0]      dcnt_q, dcnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            overrun_q, overrun_d;
    logic            capture;
    logic            is_last;
    logic [BW-1:0]   chunk;
    logic [EL_W-1:0] elem;

    // Snapshot is deliberately left out of reset; it is only read in SEND.
    logic [EL_W-1:0] shadow [ROWS][COLS];

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    shadow[r][c] <= core_out_z[(r*COLS + c)*EL_W +: EL_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            beat_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            beat_q    <= beat_d;
            col_q     <= col_d;
            row_q     <= row_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        beat_d    = beat_q;
        col_d     = col_q;
        row_d     = row_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        is_last   = (row_q == ROW_MAX) && (col_q == COL_MAX) && (beat_q == BEAT_MAX);

        case (state_q)
            IDLE: begin
                if (err_clr) overrun_d = 1'b0;
                if (init) begin
                    if (INIT_DELAY == 0) begin
                        capture = 1'b1;
                        state_d = SEND;
                    end else begin
                        dcnt_d  = 8'(INIT_DELAY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (init) overrun_d = 1'b1;
                if (dcnt_q == 8'd0) begin
                    capture = 1'b1;
                    state_d = SEND;
                end else begin
                    dcnt_d = dcnt_q - 8'd1;
                end
            end
            SEND: begin
                if (init) overrun_d = 1'b1;
                if (tx_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                        beat_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (beat_q == BEAT_MAX) begin
                        beat_d = '0;
                        if (col_q == COL_MAX) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MSB-first only reverses chunk order; lane order inside a chunk is untouched.
    always_comb begin
        elem     = shadow[row_q][col_q];
        chunk    = MSB_FIRST ? (BEAT_MAX - beat_q) : beat_q;
        tx_valid = (state_q == SEND);
        busy     = (state_q != IDLE);
        data_out = tx_valid ? elem[chunk*LANES +: LANES] : '0;
        tx_first = tx_valid && (row_q == '0) && (col_q == '0) && (beat_q == '0);
        tx_last  = tx_valid && is_last;
        overrun  = overrun_q;
    end

endmodule

// File: tb/tb_output_serializer.sv
// Directed bench: default 2x2 LSB-first serializer plus a 4-lane MSB-first variant
// with zero start delay.
module tb_output_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] a_z;
    logic        a_init, a_err_clr, a_ready;
    logic [0:0]  a_data;
    logic        a_valid, a_first, a_last, a_busy, a_overrun;

    logic [63:0] b_z;
    logic        b_init, b_err_clr, b_ready;
    logic [3:0]  b_data;
    logic        b_valid, b_first, b_last, b_busy, b_overrun;

    output_serializer u_a (
        .clk(clk), .rst(rst), .core_out_z(a_z), .init(a_init), .err_clr(a_err_clr),
        .data_out(a_data), .tx_valid(a_valid), .tx_ready(a_ready), .tx_first(a_first),
        .tx_last(a_last), .busy(a_busy), .overrun(a_overrun)
    );

    output_serializer #(.D_W(8), .ROWS(2), .COLS(2), .LANES(4), .INIT_DELAY(0), .MSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst(rst), .core_out_z(b_z), .init(b_init), .err_clr(b_err_clr),
        .data_out(b_data), .tx_valid(b_valid), .tx_ready(b_ready), .tx_first(b_first),
        .tx_last(b_last), .busy(b_busy), .overrun(b_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_a(output int lat);
        a_init = 1'b1;
        @(negedge clk);
        a_init = 1'b0;
        lat = 1;
        while (!a_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Collects up to 'stop' accepted beats; optionally injects init+err_clr on beat 'inj'.
    task automatic recv_a(input bit bp, input int stop, input int inj,
                          output logic [63:0] bits, output int n,
                          output int flag_bad, output int stall_bad);
        logic prev_stall, prev_data;
        bits = '0; n = 0; flag_bad = 0; stall_bad = 0;
        prev_stall = 1'b0; prev_data = 1'b0;
        for (int cyc = 0; cyc < 600 && n < stop; cyc++) begin
            if (prev_stall && (a_valid !== 1'b1 || a_data[0] !== prev_data)) stall_bad++;
            a_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            a_init    = (n == inj) && a_valid && a_ready;
            a_err_clr = (n == inj) && a_valid && a_ready;
            if (a_valid && a_ready) begin
                bits[n] = a_data[0];
                if (a_first !== (n == 0))  flag_bad++;
                if (a_last  !== (n == 63)) flag_bad++;
                n++;
            end
            prev_stall = a_valid && !a_ready;
            prev_data  = a_data[0];
            @(negedge clk);
        end
        a_ready = 1'b1; a_init = 1'b0; a_err_clr = 1'b0;
    endtask

    localparam logic [63:0] FRAME1 = 64'h1234_00FF_8000_0001;
    localparam logic [63:0] FRAME2 = 64'h0000_FFFF_0F0F_BEEF;

    initial begin
        logic [63:0] bits;
        int n, fbad, sbad, lat;

        a_z = FRAME1; a_init = 0; a_err_clr = 0; a_ready = 1;
        b_z = {16'h9ABC, 16'h5678, 16'h1234, 16'hA5C3};
        b_init = 0; b_err_clr = 0; b_ready = 1;

        #1 rst = 1'b1;
        #5;
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_overrun", a_overrun, 0);
        check("rst_data", a_data, 0);
        check("rst_b_valid", b_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, tx_ready held high
        pulse_a(lat);
        check("a_latency", lat, 3);
        recv_a(1'b0, 64, -1, bits, n, fbad, sbad);
        check("a_nbeats", n, 64);
        check("a_first_el", bits[15:0], 16'h0001);
        check("a_frame", bits, FRAME1);
        check("a_flags", fbad, 0);
        check("a_valid_after", a_valid, 0);
        check("a_busy_after", a_busy, 0);
        check("a_overrun_clean", a_overrun, 0);

        // Random backpressure
        @(negedge clk);
        pulse_a(lat);
        recv_a(1'b1, 64, -1, bits, n, fbad, sbad);
        check("bp_nbeats", n, 64);
        check("bp_frame", bits, FRAME1);
        check("bp_flags", fbad, 0);
        check("bp_stable", sbad, 0);

        // Input overwritten one cycle after capture
        @(negedge clk);
        pulse_a(lat);
        a_z = '1;
        recv_a(1'b0, 64, -1, bits, n, fbad, sbad);
        check("ovw_frame", bits, FRAME1);
        a_z = FRAME1;

        // Init (with err_clr) mid-SEND
        @(negedge clk);
        pulse_a(lat);
        recv_a(1'b0, 64, 10, bits, n, fbad, sbad);
        check("mid_frame", bits, FRAME1);
        check("mid_flags", fbad, 0);
        check("mid_overrun", a_overrun, 1);
        repeat (3) @(negedge clk);
        check("mid_idle", a_busy, 0);
        check("mid_overrun_sticky", a_overrun, 1);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;
        check("errclr_overrun", a_overrun, 0);

        // Init coincident with final accepted beat is ignored
        pulse_a(lat);
        recv_a(1'b0, 64, 63, bits, n, fbad, sbad);
        check("last_frame", bits, FRAME1);
        check("last_overrun", a_overrun, 1);
        repeat (3) @(negedge clk);
        check("last_no_restart", a_busy, 0);
        a_err_clr = 1'b1;
        @(negedge clk);
        a_err_clr = 1'b0;

        // Fresh frame with new data
        a_z = FRAME2;
        pulse_a(lat);
        recv_a(1'b0, 64, -1, bits, n, fbad, sbad);
        check("new_frame", bits, FRAME2);
        check("new_overrun", a_overrun, 0);

        // Async reset mid-frame
        @(negedge clk);
        pulse_a(lat);
        recv_a(1'b0, 20, 5, bits, n, fbad, sbad);
        check("pre_rst_valid", a_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", a_valid, 0);
        check("arst_busy", a_busy, 0);
        check("arst_overrun", a_overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_a(lat);
        check("post_rst_latency", lat, 3);
        recv_a(1'b0, 64, -1, bits, n, fbad, sbad);
        check("post_rst_nbeats", n, 64);
        check("post_rst_frame", bits, FRAME2);
        check("post_rst_flags", fbad, 0);

        // Four lanes, MSB chunk first, zero start delay
        @(negedge clk);
        b_init = 1'b1;
        @(negedge clk);
        b_init = 1'b0;
        lat = 1;
        while (!b_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b_latency", lat, 1);
        bits = '0; n = 0; fbad = 0;
        for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
            if (b_valid) begin
                bits[n*4 +: 4] = b_data;
                if (b_first !== (n == 0))  fbad++;
                if (b_last  !== (n == 15)) fbad++;
                n++;
            end
            @(negedge clk);
        end
        check("b_nbeats", n, 16);
        check("b_first4", bits[15:0], 16'h3C5A);
        check("b_frame", bits, 64'hCBA9_8765_4321_3C5A);
        check("b_flags", fbad, 0);
        check("b_valid_after", b_valid, 0);
        check("b_overrun", b_overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
